// File: rtl/sram_arbiter.sv
// sram_arbiter: three-way arbiter and access sequencer for the shared external SRAM pair.
// Requesters are the VGA refresh fetch, the CPU sdram port and the CPU vram port.
// Optional grant statistics are built when SRAM_ARB_STATS_EN is defined.
module sram_arbiter #(
  parameter int unsigned WAIT_CYCLES  = 2,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vga_req,
  input  logic [17:0] vga_addr,
  output logic        vga_done,
  input  logic        sd_req,
  input  logic        sd_write,
  input  logic [17:0] sd_addr,
  input  logic [31:0] sd_wdata,
  output logic        sd_done,
  input  logic        vr_req,
  input  logic        vr_write,
  input  logic [17:0] vr_addr,
  input  logic [31:0] vr_wdata,
  output logic        vr_done,
  output logic [31:0] rdata,
  output logic        busy,
  output logic [17:0] sram_a,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic [31:0] sram_out,
  input  logic [31:0] sram_in,
  output logic [15:0] stat_vga,
  output logic [15:0] stat_sd,
  output logic [15:0] stat_vr
);

  if (WAIT_CYCLES < 2) begin : gen_bad_wait
    $error("sram_arbiter: WAIT_CYCLES must be at least 2");
  end
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : gen_bad_starve
    $error("sram_arbiter: STARVE_LIMIT must be in 1..255");
  end

  localparam int unsigned CntW = $clog2(WAIT_CYCLES);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StDone} state_e;
  typedef enum logic [1:0] {GntNone, GntVga, GntSd, GntVr} gnt_e;

  state_e           state_q, state_d;
  gnt_e             gnt_q, gnt_d;
  logic [17:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             write_q, write_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             ce_n_q, ce_n_d;
  logic             oe_n_q, oe_n_d;
  logic             we_n_q, we_n_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             vga_done_q, vga_done_d;
  logic             sd_done_q, sd_done_d;
  logic             vr_done_q, vr_done_d;
  logic [7:0]       starve_q, starve_d;
  logic             last_vr_q, last_vr_d;
  logic             grant_fire;

  logic cpu_pend;
  logic pick_vr;
  logic starve_full;

  assign cpu_pend    = sd_req | vr_req;
  // With both CPU ports pending, the one that did not win last time goes next.
  assign pick_vr     = vr_req & ~(sd_req & last_vr_q);
  assign starve_full = (starve_q == 8'(STARVE_LIMIT));

  // Next-state: arbitration in IDLE, strobe sequencing through SETUP/ACCESS/DONE.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    write_d    = write_q;
    cnt_d      = cnt_q;
    ce_n_d     = ce_n_q;
    oe_n_d     = oe_n_q;
    we_n_d     = we_n_q;
    rdata_d    = rdata_q;
    vga_done_d = 1'b0;
    sd_done_d  = 1'b0;
    vr_done_d  = 1'b0;
    starve_d   = starve_q;
    last_vr_d  = last_vr_q;
    grant_fire = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (vga_req && !(starve_full && cpu_pend)) begin
          grant_fire = 1'b1;
          gnt_d      = GntVga;
          addr_d     = vga_addr;
          wdata_d    = '0;
          write_d    = 1'b0;
          if (cpu_pend) begin
            starve_d = starve_full ? starve_q : starve_q + 8'd1;
          end else begin
            starve_d = '0;
          end
        end else if (cpu_pend) begin
          grant_fire = 1'b1;
          last_vr_d  = pick_vr;
          starve_d   = '0;
          if (pick_vr) begin
            gnt_d   = GntVr;
            addr_d  = vr_addr;
            wdata_d = vr_wdata;
            write_d = vr_write;
          end else begin
            gnt_d   = GntSd;
            addr_d  = sd_addr;
            wdata_d = sd_wdata;
            write_d = sd_write;
          end
        end
        if (grant_fire) begin
          state_d = StSetup;
          cnt_d   = '0;
          ce_n_d  = 1'b0;
          oe_n_d  = write_d;
          we_n_d  = 1'b1;
        end
      end
      StSetup: begin
        state_d = StAccess;
        we_n_d  = ~write_q;
      end
      StAccess: begin
        if (cnt_q == CntW'(WAIT_CYCLES - 1)) begin
          state_d    = StDone;
          ce_n_d     = 1'b1;
          oe_n_d     = 1'b1;
          we_n_d     = 1'b1;
          if (!write_q) begin
            rdata_d = sram_in;
          end
          vga_done_d = (gnt_q == GntVga);
          sd_done_d  = (gnt_q == GntSd);
          vr_done_d  = (gnt_q == GntVr);
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; address and write data hold through DONE for hold time.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      gnt_q      <= GntNone;
      addr_q     <= '0;
      wdata_q    <= '0;
      write_q    <= 1'b0;
      cnt_q      <= '0;
      ce_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
      rdata_q    <= '0;
      vga_done_q <= 1'b0;
      sd_done_q  <= 1'b0;
      vr_done_q  <= 1'b0;
      starve_q   <= '0;
      last_vr_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      write_q    <= write_d;
      cnt_q      <= cnt_d;
      ce_n_q     <= ce_n_d;
      oe_n_q     <= oe_n_d;
      we_n_q     <= we_n_d;
      rdata_q    <= rdata_d;
      vga_done_q <= vga_done_d;
      sd_done_q  <= sd_done_d;
      vr_done_q  <= vr_done_d;
      starve_q   <= starve_d;
      last_vr_q  <= last_vr_d;
    end
  end

  assign sram_a    = addr_q;
  assign sram_out  = wdata_q;
  assign sram_ce_n = ce_n_q;
  assign sram_oe_n = oe_n_q;
  assign sram_we_n = we_n_q;
  assign rdata     = rdata_q;
  assign vga_done  = vga_done_q;
  assign sd_done   = sd_done_q;
  assign vr_done   = vr_done_q;
  assign busy      = (state_q != StIdle);

`ifdef SRAM_ARB_STATS_EN
  logic [15:0] stat_vga_q, stat_sd_q, stat_vr_q;

  // Saturating grant counters, bumped on every IDLE->SETUP transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_vga_q <= '0;
      stat_sd_q  <= '0;
      stat_vr_q  <= '0;
    end else if (grant_fire) begin
      unique case (gnt_d)
        GntVga:  if (stat_vga_q != 16'hFFFF) stat_vga_q <= stat_vga_q + 16'd1;
        GntSd:   if (stat_sd_q != 16'hFFFF) stat_sd_q <= stat_sd_q + 16'd1;
        GntVr:   if (stat_vr_q != 16'hFFFF) stat_vr_q <= stat_vr_q + 16'd1;
        default: ;
      endcase
    end
  end

  assign stat_vga = stat_vga_q;
  assign stat_sd  = stat_sd_q;
  assign stat_vr  = stat_vr_q;
`else
  assign stat_vga = '0;
  assign stat_sd  = '0;
  assign stat_vr  = '0;
`endif

endmodule
